// File: rtl/race_game_ctrl.sv
// Per-frame game sequencer for the VGA racer: steps the race FSM once per
// vsync and publishes level, scroll, player position, score and lives.
module race_game_ctrl #(
  parameter int FRAMES_PER_LEVEL = 600,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CRASH_FRAMES     = 120,
  parameter int LIVES            = 3,
  parameter int X_MIN            = 200,
  parameter int X_MAX            = 408,
  parameter int X_START          = 304,
  parameter int X_STEP           = 4
) (
  input  logic        vga_clk,
  input  logic        wb_rst_i,
  input  logic        vsync,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        pause,
  input  logic        collision,
  output logic        frame_tick,
  output logic [2:0]  state,
  output logic [1:0]  level,
  output logic [9:0]  scroll_y,
  output logic [9:0]  player_x,
  output logic [15:0] score,
  output logic [1:0]  lives
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    CRASH = 3'd4,
    OVER  = 3'd5
  } st_e;

  localparam logic [15:0] CD_LAST = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [15:0] CR_LAST = 16'(CRASH_FRAMES - 1);
  localparam logic [15:0] FL_LAST = 16'(FRAMES_PER_LEVEL - 1);
  localparam logic [9:0]  XMIN    = 10'(X_MIN);
  localparam logic [9:0]  XMAX    = 10'(X_MAX);
  localparam logic [9:0]  XSTART  = 10'(X_START);
  localparam logic [9:0]  XSTEP   = 10'(X_STEP);
  localparam logic [9:0]  XLO     = 10'(X_MIN + X_STEP);
  localparam logic [9:0]  XHI     = 10'(X_MAX - X_STEP);
  localparam logic [1:0]  LIVES0  = 2'(LIVES);

  st_e         state_q;
  logic        vs_q, vs_p_q, tick_q;
  logic        start_q, spend_q, col_q;
  logic [1:0]  level_q, lives_q;
  logic [9:0]  scroll_q, x_q;
  logic [15:0] score_q, cnt_q, fc_q;

  logic        hit, start_rise;
  logic [9:0]  scroll_sum, scroll_d, x_d;
  logic [15:0] score_d;

  always_comb begin
    hit        = col_q | collision;
    start_rise = start & ~start_q;
    // step is 2*(level+1), at most 8, so the sum never exceeds 487
    scroll_sum = scroll_q + {7'd0, level_q, 1'b0} + 10'd2;
    scroll_d   = (scroll_sum >= 10'd480) ? scroll_sum - 10'd480 : scroll_sum;
    x_d        = x_q;
    if (move_left && !move_right)
      x_d = (x_q <= XLO) ? XMIN : x_q - XSTEP;
    else if (move_right && !move_left)
      x_d = (x_q >= XHI) ? XMAX : x_q + XSTEP;
    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
  end

  always_ff @(posedge vga_clk) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      vs_q     <= 1'b1;
      vs_p_q   <= 1'b1;
      tick_q   <= 1'b0;
      start_q  <= 1'b0;
      spend_q  <= 1'b0;
      col_q    <= 1'b0;
      level_q  <= 2'd0;
      lives_q  <= LIVES0;
      scroll_q <= 10'd0;
      x_q      <= XSTART;
      score_q  <= 16'd0;
      cnt_q    <= 16'd0;
      fc_q     <= 16'd0;
    end else begin
      vs_q    <= vsync;
      vs_p_q  <= vs_q;
      tick_q  <= vs_p_q & ~vs_q;
      start_q <= start;
      // a press landing on the tick cycle is kept for the next frame
      spend_q <= tick_q ? start_rise : (spend_q | start_rise);
      col_q   <= ~tick_q & (col_q | (collision & (state_q == RUN)));
      unique case (state_q)
        IDLE, OVER: begin
          if (tick_q && spend_q) begin
            state_q  <= COUNT;
            cnt_q    <= CD_LAST;
            score_q  <= 16'd0;
            level_q  <= 2'd0;
            fc_q     <= 16'd0;
            lives_q  <= LIVES0;
            x_q      <= XSTART;
            scroll_q <= 10'd0;
          end
        end
        COUNT: begin
          if (tick_q) begin
            if (cnt_q == 16'd0) state_q <= RUN;
            else cnt_q <= cnt_q - 16'd1;
          end
        end
        RUN: begin
          if (tick_q) begin
            if (hit) begin
              if (lives_q == 2'd1) begin
                lives_q <= 2'd0;
                state_q <= OVER;
              end else begin
                lives_q <= lives_q - 2'd1;
                cnt_q   <= CR_LAST;
                state_q <= CRASH;
              end
            end else if (pause) begin
              state_q <= PAUSE;
            end else begin
              scroll_q <= scroll_d;
              x_q      <= x_d;
              score_q  <= score_d;
              if (fc_q == FL_LAST) begin
                fc_q <= 16'd0;
                if (level_q != 2'd3) level_q <= level_q + 2'd1;
              end else begin
                fc_q <= fc_q + 16'd1;
              end
            end
          end
        end
        PAUSE: begin
          if (tick_q && !pause) state_q <= RUN;
        end
        CRASH: begin
          if (tick_q) begin
            if (cnt_q == 16'd0) begin
              state_q <= RUN;
              x_q     <= XSTART;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_tick = tick_q;
  assign state      = state_q;
  assign level      = level_q;
  assign scroll_y   = scroll_q;
  assign player_x   = x_q;
  assign score      = score_q;
  assign lives      = lives_q;

endmodule
